// File: rtl/pipe_ctrl_pkg.sv
// Shared core package for the pipeline controller.
//   state_t        : controller FSM states
//   FWD_RF/EX/WB   : operand-source select codes driven on fwd_rs1/fwd_rs2
//   NUM_SRC        : number of decode source operands compared per cycle
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_INTERLOCK = 2'd1,
        ST_FREEZE    = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_EX = 2'd1;
    localparam logic [1:0] FWD_WB = 2'd2;

    localparam int NUM_SRC = 2;

endpackage

// File: rtl/pipe_ctrl_hazard_cmp.sv
// hazard_cmp: compares one decode source operand against the execute and
// writeback slots and returns {hazard, fwd} for that operand.
// Macro PIPE_CTRL_FWD_EN: when defined, writeback matches and non-load
// execute matches are forwarded; only a load in execute is a hazard.
// When undefined, every match is a hazard and fwd is always FWD_RF.
// Ports:
//   dec_valid, use_src, src       : decode operand and whether it is read
//   ex_vld, ex_wr, ex_load, ex_rd : execute slot state
//   wb_vld, wb_wr, wb_rd          : writeback slot state
//   hazard                        : operand cannot be supplied this cycle
//   fwd                           : operand source select
module hazard_cmp
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic                dec_valid,
    input  logic                use_src,
    input  logic [REG_BITS-1:0] src,
    input  logic                ex_vld,
    input  logic                ex_wr,
    input  logic                ex_load,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                wb_vld,
    input  logic                wb_wr,
    input  logic [REG_BITS-1:0] wb_rd,
    output logic                hazard,
    output logic [1:0]          fwd
);

    logic act;
    logic ex_hit;
    logic wb_hit;

    // x0 is hardwired zero: a zero source never matches, which also keeps
    // a zero rd out of the match since src must equal rd.
    assign act    = dec_valid & use_src & (src != '0);
    assign ex_hit = act & ex_vld & ex_wr & (ex_rd == src);
    assign wb_hit = act & wb_vld & wb_wr & (wb_rd == src);

`ifdef PIPE_CTRL_FWD_EN
    // Load data only exists at writeback, so a load in execute must wait.
    assign hazard = ex_hit & ex_load;

    // Execute holds the younger write, so it wins over writeback.
    always_comb begin
        fwd = FWD_RF;
        if (ex_hit)      fwd = FWD_EX;
        else if (wb_hit) fwd = FWD_WB;
    end
`else
    logic unused_load;
    assign unused_load = ex_load;

    assign hazard = ex_hit | wb_hit;
    assign fwd    = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard / stall / flush controller for a decode-execute-writeback
// integer pipeline. Tracks the execute and writeback slots and decides each
// cycle whether decode advances, stalls behind a bubble, freezes on a busy
// memory, or is flushed by a redirect.
// Macro PIPE_CTRL_FWD_EN enables operand forwarding (see hazard_cmp).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   dec_*                      : decode-stage instruction fields
//   mem_busy                   : data memory cannot accept/retire
//   redirect                   : taken branch/jump resolved in execute
//   stall, flush               : decode/execute hold, decode discard
//   ex_valid, wb_valid         : slot occupancy
//   fwd_rs1, fwd_rs2           : operand source selects
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int     REG_BITS    = 5,
    parameter state_t RESET_STATE = ST_RUN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic [REG_BITS-1:0] dec_rs1,
    input  logic [REG_BITS-1:0] dec_rs2,
    input  logic                dec_use_rs1,
    input  logic                dec_use_rs2,
    input  logic [REG_BITS-1:0] dec_rd,
    input  logic                dec_wr,
    input  logic                dec_load,
    input  logic                mem_busy,
    input  logic                redirect,
    output logic                stall,
    output logic                flush,
    output logic                ex_valid,
    output logic                wb_valid,
    output logic [1:0]          fwd_rs1,
    output logic [1:0]          fwd_rs2
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic                wr;
        logic                load;
    } ex_slot_t;

    typedef struct packed {
        logic [REG_BITS-1:0] rd;
        logic                wr;
    } wb_slot_t;

    // vld_pipe[1] = execute slot valid, vld_pipe[2] = writeback slot valid
    logic [STAGES:1] vld_pipe, vld_d;
    ex_slot_t        ex_q, ex_d;
    wb_slot_t        wb_q, wb_d;
    state_t          state, state_nx;
    logic            pend_q, pend_d;
    logic            hazard;

    logic [NUM_SRC-1:0][REG_BITS-1:0] src;
    logic [NUM_SRC-1:0]               src_use;
    logic [NUM_SRC-1:0]               src_hz;
    logic [NUM_SRC-1:0][1:0]          src_fwd;

    assign src     = {dec_rs2, dec_rs1};
    assign src_use = {dec_use_rs2, dec_use_rs1};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cmp
        hazard_cmp #(.REG_BITS(REG_BITS)) u_cmp (
            .dec_valid (dec_valid),
            .use_src   (src_use[i]),
            .src       (src[i]),
            .ex_vld    (vld_pipe[1]),
            .ex_wr     (ex_q.wr),
            .ex_load   (ex_q.load),
            .ex_rd     (ex_q.rd),
            .wb_vld    (vld_pipe[2]),
            .wb_wr     (wb_q.wr),
            .wb_rd     (wb_q.rd),
            .hazard    (src_hz[i]),
            .fwd       (src_fwd[i])
        );
    end

    assign hazard   = |src_hz;
    assign ex_valid = vld_pipe[1];
    assign wb_valid = vld_pipe[2];

    always_comb begin
        stall   = 1'b0;
        flush   = 1'b0;
        fwd_rs1 = FWD_RF;
        fwd_rs2 = FWD_RF;
        pend_d  = pend_q;
        vld_d   = vld_pipe;
        ex_d    = ex_q;
        wb_d    = wb_q;

        // Outputs stay quiet while reset is held; the register block
        // performs the actual clear.
        if (rst_n) begin
            fwd_rs1 = src_fwd[0];
            fwd_rs2 = src_fwd[1];
            if (mem_busy) begin
                // Freeze: nothing moves; remember a redirect for later.
                stall  = 1'b1;
                pend_d = pend_q | redirect;
            end else begin
                flush  = redirect | pend_q;
                pend_d = 1'b0;
                // A flush discards decode, so its hazard is irrelevant.
                stall  = hazard & ~flush;

                vld_d[2] = vld_pipe[1];
                wb_d     = '{rd: ex_q.rd, wr: ex_q.wr};

                if (stall || flush || !dec_valid) begin
                    vld_d[1] = 1'b0;
                    ex_d     = '0;
                end else begin
                    vld_d[1] = 1'b1;
                    ex_d     = '{rd: dec_rd, wr: dec_wr, load: dec_load};
                end
            end
        end

        // Every state leaves on the same conditions; an unused encoding
        // falls back to ST_RUN.
        case (state)
            ST_RUN, ST_INTERLOCK, ST_FREEZE: begin
                if (mem_busy)   state_nx = ST_FREEZE;
                else if (stall) state_nx = ST_INTERLOCK;
                else            state_nx = ST_RUN;
            end
            default: state_nx = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RESET_STATE;
            vld_pipe <= '0;
            pend_q   <= 1'b0;
            ex_q     <= '0;
            wb_q     <= '0;
        end else begin
            state    <= state_nx;
            vld_pipe <= vld_d;
            pend_q   <= pend_d;
            ex_q     <= ex_d;
            wb_q     <= wb_d;
        end
    end

endmodule
